// File: rtl/fft_sdf_ctrl_pkg.sv
// ============================================================================
// Module : fft_pkg
// Brief  : Shared types, defaults and constant helpers for the SDF FFT sequencer
//          (out_idx support is enabled by FFT_SDF_CTRL_BITREV_EN).
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fft_pkg;

    localparam int FFT_N_DEF  = 1024;
    localparam int LOG2N_DEF  = 10;
    localparam int BF_LAT_DEF = 1;
    localparam int ADDR_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        FLUSH     = 2'd2,
        DRAIN_END = 2'd3
    } state_t;

    // Enabled-cycle offset at which stage s first sees sample 0.
    function automatic int stage_off(input int s, input int fft_n, input int bf_lat);
        int off;
        off = 0;
        for (int j = 1; j < s; j++) begin
            off += (fft_n >> j) + bf_lat;
        end
        return off;
    endfunction

    function automatic int total_lat(input int fft_n, input int log2n, input int bf_lat);
        return stage_off(log2n, fft_n, bf_lat) + (fft_n >> log2n) + bf_lat;
    endfunction

    function automatic logic [15:0] bit_rev(input logic [15:0] v, input int n);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < n) r[i] = v[n-1-i];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft_sdf_ctrl_if.sv
// ============================================================================
// Module : fft_sdf_ctrl_if
// Brief  : Stream-in / pipeline-control bundle of the SDF FFT sequencer
//          (out_idx_o present when FFT_SDF_CTRL_BITREV_EN is defined).
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface fft_sdf_ctrl_if #(
    parameter int LOG2N  = 10,
    parameter int ADDR_W = 16
);
    logic                    in_valid_i;
    logic                    in_last_i;
    logic                    enable_o;
    logic [LOG2N-1:0]        ctrl_o;
    logic [LOG2N*ADDR_W-1:0] tw_addr_o;
    logic                    out_valid_o;
    logic                    out_first_o;
    logic                    busy_o;
`ifdef FFT_SDF_CTRL_BITREV_EN
    logic [LOG2N-1:0]        out_idx_o;
`endif

    // master: the sequencer; slave: the stream source / pipeline side
    modport master (
        input  in_valid_i, in_last_i,
`ifdef FFT_SDF_CTRL_BITREV_EN
        output out_idx_o,
`endif
        output enable_o, ctrl_o, tw_addr_o, out_valid_o, out_first_o, busy_o
    );

    modport slave (
        output in_valid_i, in_last_i,
`ifdef FFT_SDF_CTRL_BITREV_EN
        input  out_idx_o,
`endif
        input  enable_o, ctrl_o, tw_addr_o, out_valid_o, out_first_o, busy_o
    );

endinterface

`default_nettype wire

// File: rtl/fft_sdf_ctrl_stage_seq.sv
// ============================================================================
// Module : fft_stage_seq
// Brief  : Per-stage ctrl select and twiddle address generator, driven from the
//          next value of the global enabled-cycle counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fft_stage_seq #(
    parameter int STAGE_NO = 1,
    parameter int FFT_N    = 16,
    parameter int OFF      = 0,
    parameter int ADDR_W   = 16,
    parameter int GW       = 7
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              ld_i,
    input  wire logic [GW-1:0]     g_d_i,
    output logic                   ctrl_o,
    output logic [ADDR_W-1:0]      tw_addr_o
);
    // Only the low CW bits of the local index matter: the ctrl bit and the bits below it.
    localparam int CW = $clog2(FFT_N) - STAGE_NO + 1;
    localparam logic [CW-1:0] C_OFF  = CW'(OFF % (1 << CW));
    localparam logic [CW-1:0] C_MASK = CW'((1 << (CW - 1)) - 1);

    logic              active;
    logic [CW-1:0]     c;
    logic              ctrl_d;
    logic [ADDR_W-1:0] tw_d;

    if (OFF == 0) begin : g_no_off
        assign active = 1'b1;
    end else begin : g_off
        assign active = (g_d_i >= GW'(OFF));
    end

    always_comb begin
        c      = g_d_i[CW-1:0] - C_OFF;
        ctrl_d = active & c[CW-1];
        tw_d   = active ? (ADDR_W'(c & C_MASK) << (STAGE_NO - 1)) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_o    <= 1'b0;
            tw_addr_o <= '0;
        end else if (ld_i) begin
            ctrl_o    <= ctrl_d;
            tw_addr_o <= tw_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fft_sdf_ctrl.sv
// ============================================================================
// Module : fft_sdf_ctrl
// Brief  : Central sequencer of a radix-2 SDF FFT pipeline: enable, per-stage
//          ctrl/twiddle address, output framing. Option: FFT_SDF_CTRL_BITREV_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fft_sdf_ctrl
    import fft_pkg::*;
#(
    parameter int FFT_N  = FFT_N_DEF,
    parameter int LOG2N  = LOG2N_DEF,
    parameter int BF_LAT = BF_LAT_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  wire logic      clk,
    input  wire logic      rst,
    fft_sdf_ctrl_if.master io
);
    localparam int LAT = total_lat(FFT_N, LOG2N, BF_LAT);
    localparam int GW  = $clog2(FFT_N + LAT) + 1;
    localparam logic [GW-1:0] G_LAT    = GW'(LAT);
    localparam logic [GW-1:0] G_WRAP   = GW'(LAT + FFT_N - 1);
    localparam logic [GW-1:0] G_FL_END = GW'(LAT - 1);

    state_t                  state_q;
    logic [GW-1:0]           g_q, g_d;
    logic [GW-1:0]           fl_q;
    logic                    en, clr, ld;
    logic                    out_valid_q, out_first_q;
    logic [LOG2N-1:0]        stage_ctrl;
    logic [LOG2N*ADDR_W-1:0] stage_tw;
`ifdef FFT_SDF_CTRL_BITREV_EN
    logic [LOG2N-1:0]        out_idx_q;
`endif

    // Once every stage is active, g folds back by FFT_N so it stays below FFT_N+LAT
    // while every stage's index modulo FFT_N is preserved.
    always_comb begin
        unique case (state_q)
            IDLE, RUN: en = io.in_valid_i;
            FLUSH:     en = 1'b1;
            default:   en = 1'b0;
        endcase
        clr = (state_q == DRAIN_END);
        ld  = en | clr;
        g_d = g_q;
        if (clr) begin
            g_d = '0;
        end else if (en) begin
            g_d = (g_q == G_WRAP) ? G_LAT : g_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            g_q         <= '0;
            fl_q        <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
`ifdef FFT_SDF_CTRL_BITREV_EN
            out_idx_q   <= '0;
`endif
        end else begin
            g_q         <= g_d;
            out_valid_q <= en && (g_q >= G_LAT);
            out_first_q <= en && (g_q == G_LAT);
`ifdef FFT_SDF_CTRL_BITREV_EN
            if (en && (g_q >= G_LAT)) begin
                out_idx_q <= LOG2N'(bit_rev(16'(g_q - G_LAT), LOG2N));
            end
`endif
            unique case (state_q)
                IDLE: begin
                    fl_q <= '0;
                    if (io.in_valid_i) state_q <= io.in_last_i ? FLUSH : RUN;
                end
                RUN: begin
                    fl_q <= '0;
                    if (io.in_valid_i && io.in_last_i) state_q <= FLUSH;
                end
                FLUSH: begin
                    fl_q <= fl_q + 1'b1;
                    if (fl_q == G_FL_END) state_q <= DRAIN_END;
                end
                default: begin
                    fl_q    <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    for (genvar s = 1; s <= LOG2N; s++) begin : g_stage
        fft_stage_seq #(
            .STAGE_NO (s),
            .FFT_N    (FFT_N),
            .OFF      (stage_off(s, FFT_N, BF_LAT)),
            .ADDR_W   (ADDR_W),
            .GW       (GW)
        ) u_seq (
            .clk       (clk),
            .rst       (rst),
            .ld_i      (ld),
            .g_d_i     (g_d),
            .ctrl_o    (stage_ctrl[s-1]),
            .tw_addr_o (stage_tw[s*ADDR_W-1 -: ADDR_W])
        );
    end

    assign io.enable_o    = en;
    assign io.ctrl_o      = stage_ctrl;
    assign io.tw_addr_o   = stage_tw;
    assign io.out_valid_o = out_valid_q;
    assign io.out_first_o = out_first_q;
    assign io.busy_o      = (state_q != IDLE);
`ifdef FFT_SDF_CTRL_BITREV_EN
    assign io.out_idx_o   = out_idx_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fft_sdf_ctrl.sv
// ============================================================================
// Module : tb_fft_sdf_ctrl
// Brief  : Self-checking bench for fft_sdf_ctrl (FFT_N=16); out_idx checked when
//          FFT_SDF_CTRL_BITREV_EN is defined.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_fft_sdf_ctrl;
    localparam int N   = 16;
    localparam int LG  = 4;
    localparam int BFL = 1;
    localparam int AW  = 16;
    localparam int L   = 19;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fft_sdf_ctrl_if #(.LOG2N(LG), .ADDR_W(AW)) io ();

    fft_sdf_ctrl #(.FFT_N(N), .LOG2N(LG), .BF_LAT(BFL), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    task automatic chk(input string name, input int t, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%0h want=%0h", name, t, act, exp);
        end
    endtask

    function automatic int m_off(input int s);
        int o;
        o = 0;
        for (int j = 1; j < s; j++) o += (N / (2 ** j)) + BFL;
        return o;
    endfunction

    function automatic logic [LG-1:0] m_ctrl(input int n);
        logic [LG-1:0] r;
        r = '0;
        for (int s = 1; s <= LG; s++) begin
            if (n >= m_off(s)) r[s-1] = ((((n - m_off(s)) % N) / (N / (2 ** s))) % 2) == 1;
        end
        return r;
    endfunction

    function automatic logic [LG*AW-1:0] m_tw(input int n);
        logic [LG*AW-1:0] r;
        int c;
        r = '0;
        for (int s = 1; s <= LG; s++) begin
            if (n >= m_off(s)) begin
                c = (n - m_off(s)) % N;
                r[(s-1)*AW +: AW] = AW'((c % (N / (2 ** s))) * (2 ** (s - 1)));
            end
        end
        return r;
    endfunction

    function automatic logic [LG-1:0] m_rev(input int v);
        logic [LG-1:0] r;
        for (int i = 0; i < LG; i++) r[i] = ((v / (2 ** (LG - 1 - i))) % 2) == 1;
        return r;
    endfunction

    // One stream session: the expected enable follows in_valid up to the last
    // sample, then L flush cycles, one drain cycle, then idle.
    task automatic session(input logic [63:0] vpat, input int lastc, input int rst_at, input int tag,
                           output int n_ov, output int first_ov_t, output logic [63:0] of_mask,
                           output logic [23:0] idx_seq);
        int n, pn, f, tot;
        bit pen, vin, een, ebusy, eov, eof;
        n = 0; pn = 0; pen = 1'b0; f = -1; tot = lastc + L + 4;
        n_ov = 0; first_ov_t = -1; of_mask = '0; idx_seq = '0;
        for (int i = 0; i < 64; i++) if (f < 0 && vpat[i]) f = i;
        for (int t = 0; t < tot; t++) begin
            @(negedge clk);
            vin = (t <= lastc) && vpat[t];
            io.in_valid_i = vin;
            io.in_last_i  = (t == lastc);
            if (t == rst_at) begin
                io.in_valid_i = 1'b0;
                io.in_last_i  = 1'b0;
                rst = 1'b1;
                #1;
                chk("midrst_enable", t, 64'(io.enable_o), 64'd0);
                chk("midrst_ctrl", t, 64'(io.ctrl_o), 64'd0);
                chk("midrst_tw", t, 64'(io.tw_addr_o), 64'd0);
                chk("midrst_out_valid", t, 64'(io.out_valid_o), 64'd0);
                chk("midrst_out_first", t, 64'(io.out_first_o), 64'd0);
                chk("midrst_busy", t, 64'(io.busy_o), 64'd0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            #1;
            een   = (t <= lastc) ? vin : (t <= lastc + L);
            ebusy = (t > f) && (t <= lastc + L + 1);
            eov   = pen && (pn >= L);
            eof   = eov && (((pn - L) % N) == 0);
            chk("enable", t, 64'(io.enable_o), 64'(een));
            chk("ctrl", t, 64'(io.ctrl_o), 64'(m_ctrl(n)));
            chk("tw_addr", t, 64'(io.tw_addr_o), 64'(m_tw(n)));
            chk("out_valid", t, 64'(io.out_valid_o), 64'(eov));
            chk("out_first", t, 64'(io.out_first_o), 64'(eof));
            chk("busy", t, 64'(io.busy_o), 64'(ebusy));
`ifdef FFT_SDF_CTRL_BITREV_EN
            if (eov) chk("out_idx", t, 64'(io.out_idx_o), 64'(m_rev((pn - L) % N)));
            if (io.out_valid_o && n_ov < 6) idx_seq = {idx_seq[19:0], 4'(io.out_idx_o)};
`endif
            if (tag == 1 && t == 12) begin
                chk("lit_ctrl_g12", t, 64'(io.ctrl_o), 64'h1);
                chk("lit_tw_g12", t, 64'(io.tw_addr_o), 64'h0000_0000_0006_0004);
            end
            if (tag == 1 && t == 18) begin
                chk("lit_ctrl_g18", t, 64'(io.ctrl_o), 64'h8);
                chk("lit_tw_g18", t, 64'(io.tw_addr_o), 64'h0000_0000_0002_0002);
            end
            if (tag == 3 && t == 6) begin
                chk("lit_stall_enable", t, 64'(io.enable_o), 64'h0);
                chk("lit_stall_tw", t, 64'(io.tw_addr_o), 64'h5);
            end
            if (io.out_valid_o) begin
                if (first_ov_t < 0) first_ov_t = t;
                if (io.out_first_o && n_ov < 64) of_mask[n_ov] = 1'b1;
                n_ov++;
            end
            pen = een;
            pn  = n;
            if (een) n++;
            if (t == lastc + L + 1) n = 0;
        end
        io.in_valid_i = 1'b0;
        io.in_last_i  = 1'b0;
    endtask

    initial begin
        int          ov, fo;
        logic [63:0] om;
        logic [23:0] is;
        io.in_valid_i = 1'b0;
        io.in_last_i  = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_enable", 0, 64'(io.enable_o), 64'd0);
        chk("rst_ctrl", 0, 64'(io.ctrl_o), 64'd0);
        chk("rst_tw", 0, 64'(io.tw_addr_o), 64'd0);
        chk("rst_out_valid", 0, 64'(io.out_valid_o), 64'd0);
        chk("rst_out_first", 0, 64'(io.out_first_o), 64'd0);
        chk("rst_busy", 0, 64'(io.busy_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        session(64'hFFFF, 15, -1, 1, ov, fo, om, is);
        chk("s1_out_count", 0, 64'(ov), 64'd16);
        chk("s1_first_out_cycle", 0, 64'(fo), 64'd20);
        chk("s1_first_mask", 0, om, 64'h1);
`ifdef FFT_SDF_CTRL_BITREV_EN
        chk("s1_idx_seq", 0, 64'(is), 64'h084C2A);
`endif

        session(64'hFFFF, 15, 7, 2, ov, fo, om, is);

        session(64'h7FF1F, 18, -1, 3, ov, fo, om, is);
        chk("s3_stall_out_count", 0, 64'(ov), 64'd16);

        session(64'hFFFF_FFFF, 31, -1, 4, ov, fo, om, is);
        chk("s4_b2b_out_count", 0, 64'(ov), 64'd32);
        chk("s4_b2b_first_mask", 0, om, 64'h1_0001);

        session(64'h1F, 4, -1, 5, ov, fo, om, is);
        chk("s5_partial_out_count", 0, 64'(ov), 64'd5);
        chk("s5_partial_first_mask", 0, om, 64'h1);

        session(64'h1, 0, -1, 6, ov, fo, om, is);
        chk("s6_single_out_count", 0, 64'(ov), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
